// File: rtl/exc_ctrl.sv
// Exception controller: takes illegal-opcode and interrupt exceptions and registers the PC redirect.
// Build option EXC_IRQ_LATCH_EN: interrupts are held pending until taken, not sampled as a level.
module exc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
   input  logic        illop,
   input  logic        inst_valid,
   input  logic [31:0] pc,
   output logic        exc_req,
   output logic        exc_sel,
   output logic [31:0] epc,
   output logic        epc_we,
   output logic        irq_pending,
   output logic [7:0]  exc_cnt
);

   typedef enum logic [1:0] {KERNEL = 2'd0, HOLD = 2'd1, USER = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        qual_ill_p0;
   logic        take_ill_p0;
   logic        take_irq_p0;
   logic        take_p0;
   logic        pend_nxt;
   logic [31:0] epc_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign qual_ill_p0 = inst_valid & illop;
   assign take_p0     = take_ill_p0 | take_irq_p0;
   assign epc_we      = exc_req;

   // Stage p0: detection and next-state decode
   always_comb begin
      state_nxt   = state;
      take_ill_p0 = 1'b0;
      take_irq_p0 = 1'b0;
      epc_nxt     = epc;
      case (state)
         KERNEL: begin
            if (inst_valid && !pc[31]) state_nxt = HOLD;
         end
         HOLD: begin
            if (qual_ill_p0) begin
               take_ill_p0 = 1'b1;
               state_nxt   = KERNEL;
            end else if (inst_valid && !pc[31]) begin
               state_nxt = USER;
            end
         end
         USER: begin
            if (qual_ill_p0) begin
               take_ill_p0 = 1'b1;
               state_nxt   = KERNEL;
            end else if (irq_pending) begin
               take_irq_p0 = 1'b1;
               state_nxt   = KERNEL;
            end
         end
         default: state_nxt = KERNEL;
      endcase
      // Illegal op returns past the faulting instruction; an interrupt re-executes it.
      if (take_ill_p0)
         epc_nxt = {pc[31], pc[30:0] + 31'd4};
      else if (take_irq_p0)
         epc_nxt = pc;
`ifdef EXC_IRQ_LATCH_EN
      pend_nxt = take_irq_p0 ? 1'b0 : (irq | irq_pending);
`else
      pend_nxt = take_irq_p0 ? 1'b0 : irq;
`endif
   end

   // Stage p1: registered redirect request and bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= KERNEL;
         exc_req     <= 1'b0;
         exc_sel     <= 1'b0;
         epc         <= 32'h0;
         irq_pending <= 1'b0;
         exc_cnt     <= 8'h00;
      end else begin
         state       <= state_nxt;
         exc_req     <= take_p0;
         exc_sel     <= take_irq_p0;
         epc         <= epc_nxt;
         irq_pending <= pend_nxt;
         if (take_p0) exc_cnt <= sat_inc(exc_cnt);
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; expected redirects are queued as stimulus is driven and
// checked whenever the DUT raises exc_req.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq, illop, inst_valid;
   logic [31:0] pc;
   logic        exc_req, exc_sel, epc_we, irq_pending;
   logic [31:0] epc;
   logic [7:0]  exc_cnt;

   typedef struct {
      logic        sel;
      logic [31:0] epc;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   exc_ctrl dut (
      .clk(clk), .reset(reset), .irq(irq), .illop(illop), .inst_valid(inst_valid), .pc(pc),
      .exc_req(exc_req), .exc_sel(exc_sel), .epc(epc), .epc_we(epc_we),
      .irq_pending(irq_pending), .exc_cnt(exc_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic il, input logic iq, input logic [31:0] p);
      inst_valid = v;
      illop      = il;
      irq        = iq;
      pc         = p;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic sel, input logic [31:0] e);
      exp_t x;
      x.sel = sel;
      x.epc = e;
      sbq.push_back(x);
   endtask

   // Every cycle with exc_req high must match exactly one queued redirect.
   always @(negedge clk) begin
      if (reset === 1'b1 && exc_req === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_exc_req", 32'(exc_req), 32'h0);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            chk("sb_exc_sel", 32'(exc_sel), 32'(x.sel));
            chk("sb_epc", epc, x.epc);
            chk("sb_epc_we", 32'(epc_we), 32'h1);
         end
      end
   end

   initial begin
      int exp_cnt;
      reset = 1'b0; irq = 1'b0; illop = 1'b0; inst_valid = 1'b0; pc = 32'h0;
      #3;
      chk("rst_exc_req", 32'(exc_req), 32'h0);
      chk("rst_exc_sel", 32'(exc_sel), 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_epc_we", 32'(epc_we), 32'h0);
      chk("rst_irq_pending", 32'(irq_pending), 32'h0);
      chk("rst_exc_cnt", 32'(exc_cnt), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Kernel boot, then enter user through HOLD with irq raised
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 32'h8000_0000);
         chk("boot_no_exc", 32'(exc_req), 32'h0);
      end
      cyc(1, 0, 1, 32'h0000_0010);
      chk("irq_kernel_no_exc", 32'(exc_req), 32'h0);
      chk("irq_pending_set", 32'(irq_pending), 32'h1);
      cyc(1, 0, 1, 32'h0000_0014);
      chk("irq_hold_no_exc", 32'(exc_req), 32'h0);
      push(1, 32'h0000_0018);
      cyc(1, 0, 0, 32'h0000_0018);
      chk("xadr_exc_req", 32'(exc_req), 32'h1);
      chk("xadr_exc_sel", 32'(exc_sel), 32'h1);
      chk("xadr_epc", epc, 32'h0000_0018);
      chk("xadr_cnt", 32'(exc_cnt), 32'h1);
      chk("xadr_pending_clr", 32'(irq_pending), 32'h0);
      cyc(1, 0, 0, 32'h0000_0100);
      chk("xadr_one_cycle", 32'(exc_req), 32'h0);
      cyc(1, 0, 0, 32'h0000_0104);

      // Illegal opcode in user mode
      push(0, 32'h0000_0024);
      cyc(1, 1, 0, 32'h0000_0020);
      chk("ill_exc_req", 32'(exc_req), 32'h1);
      chk("ill_exc_sel", 32'(exc_sel), 32'h0);
      chk("ill_epc", epc, 32'h0000_0024);
      chk("ill_epc_we", 32'(epc_we), 32'h1);
      chk("ill_cnt", 32'(exc_cnt), 32'h2);
      cyc(0, 0, 0, 32'h0);
      chk("ill_after_req", 32'(exc_req), 32'h0);
      chk("ill_after_sel", 32'(exc_sel), 32'h0);
      chk("ill_after_we", 32'(epc_we), 32'h0);
      chk("ill_epc_hold", epc, 32'h0000_0024);
      cyc(1, 1, 0, 32'h8000_0200);
      chk("kernel_illop_ignored", 32'(exc_req), 32'h0);
      cyc(1, 0, 0, 32'h0000_0100);
      cyc(1, 0, 0, 32'h0000_0104);
      chk("back_to_user", 32'(exc_req), 32'h0);

      // Illegal opcode and irq together: illop first, irq later
      push(0, 32'h0000_0044);
      cyc(1, 1, 1, 32'h0000_0040);
      chk("prio_exc_req", 32'(exc_req), 32'h1);
      chk("prio_exc_sel", 32'(exc_sel), 32'h0);
      chk("prio_pending", 32'(irq_pending), 32'h1);
      cyc(1, 0, 1, 32'h0000_0100);
      chk("prio_kernel_no_exc", 32'(exc_req), 32'h0);
      cyc(1, 0, 1, 32'h0000_0104);
      chk("prio_hold_no_exc", 32'(exc_req), 32'h0);
      chk("prio_pending_hold", 32'(irq_pending), 32'h1);
      push(1, 32'h0000_0108);
      cyc(1, 0, 0, 32'h0000_0108);
      chk("prio_xadr_req", 32'(exc_req), 32'h1);
      chk("prio_xadr_sel", 32'(exc_sel), 32'h1);
      chk("prio_pending_clr", 32'(irq_pending), 32'h0);
      chk("prio_cnt", 32'(exc_cnt), 32'h4);

      // One-cycle irq pulse while in kernel mode
      cyc(1, 0, 1, 32'h8000_0100);
      cyc(1, 0, 0, 32'h8000_0104);
`ifdef EXC_IRQ_LATCH_EN
      chk("pulse_pending", 32'(irq_pending), 32'h1);
`else
      chk("pulse_pending", 32'(irq_pending), 32'h0);
`endif
      cyc(1, 0, 0, 32'h0000_0200);
      chk("pulse_kernel_no_exc", 32'(exc_req), 32'h0);
      cyc(1, 0, 0, 32'h0000_0204);
      chk("pulse_hold_no_exc", 32'(exc_req), 32'h0);
`ifdef EXC_IRQ_LATCH_EN
      push(1, 32'h0000_0208);
      cyc(1, 0, 0, 32'h0000_0208);
      chk("pulse_taken", 32'(exc_req), 32'h1);
`else
      cyc(1, 0, 0, 32'h0000_0208);
      chk("pulse_lost", 32'(exc_req), 32'h0);
      push(0, 32'h0000_0210);
      cyc(1, 1, 0, 32'h0000_020C);
      chk("pulse_ill_req", 32'(exc_req), 32'h1);
`endif
      chk("pulse_cnt", 32'(exc_cnt), 32'h5);

      // Saturation: 251 more exceptions through HOLD, 256 in total
      exp_cnt = 5;
      for (int i = 0; i < 251; i++) begin
         cyc(1, 0, 0, 32'h0000_0300);
         if (i == 0) chk("sat_hold_no_exc", 32'(exc_req), 32'h0);
         push(0, 32'h0000_0308);
         cyc(1, 1, 0, 32'h0000_0304);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         chk("sat_cnt", 32'(exc_cnt), 32'(exp_cnt));
      end
      chk("sat_final", 32'(exc_cnt), 32'hFF);

      // Reset during the exc_req cycle
      cyc(1, 0, 0, 32'h0000_0300);
      cyc(1, 1, 0, 32'h0000_0304);
      chk("mid_req_high", 32'(exc_req), 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", 32'(exc_req), 32'h0);
      chk("mid_rst_sel", 32'(exc_sel), 32'h0);
      chk("mid_rst_epc", epc, 32'h0);
      chk("mid_rst_we", 32'(epc_we), 32'h0);
      chk("mid_rst_cnt", 32'(exc_cnt), 32'h0);
      chk("mid_rst_pending", 32'(irq_pending), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(1, 1, 1, 32'h0000_0400);
      chk("post_rst_kernel", 32'(exc_req), 32'h0);
      cyc(1, 0, 1, 32'h0000_0404);
      chk("post_rst_hold", 32'(exc_req), 32'h0);
      push(1, 32'h0000_0408);
      cyc(1, 0, 0, 32'h0000_0408);
      chk("post_rst_xadr", 32'(exc_req), 32'h1);
      chk("post_rst_cnt", 32'(exc_cnt), 32'h1);
      cyc(0, 0, 0, 32'h0);
      cyc(0, 0, 0, 32'h0);

      chk("sb_drained", 32'(sbq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
